// File: rtl/binary_search_engine.sv
// Binary search over a sorted table held in an external synchronous RAM.
// Latency: 2 cycles per probe plus one DONE cycle (done in cycle 2P+1 after start).
// Backpressure: none; start is ignored while busy, abort cancels without a done pulse.
module binary_search_engine #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ARRAY_SIZE = 10,
  parameter  int SIGNED     = 0,
  localparam int AW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1,
  localparam int IW = $clog2(ARRAY_SIZE + 1),
  localparam int PW = $clog2(IW + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] key,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [IW-1:0]         index,
  output logic [PW-1:0]         probes
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_CMP, S_DONE} state_t;

  localparam logic [IW-1:0] N_ENTRIES = IW'(ARRAY_SIZE);

  state_t                state_q, state_d;
  logic [IW-1:0]         lo_q, lo_d, hi_q, hi_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [1:0]            mode_q, mode_d;
  logic                  found_q, found_d;
  logic [IW-1:0]         index_q, index_d;
  logic [PW-1:0]         probes_q, probes_d;

  // Midpoint of the half-open window; subtract first so lo+hi never overflows.
  logic [IW-1:0] mid;
  logic [IW-1:0] lo_n, hi_n;
  logic          data_lt, data_eq, is_exact, is_upper;

  assign mid      = lo_q + ((hi_q - lo_q) >> 1);
  assign data_lt  = (SIGNED != 0) ? ($signed(rd_data) < $signed(key_q)) : (rd_data < key_q);
  assign data_eq  = (rd_data == key_q);
  assign is_upper = (mode_q == 2'b10);
  assign is_exact = (mode_q == 2'b00) || (mode_q == 2'b11);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      key_q    <= '0;
      mode_q   <= '0;
      found_q  <= 1'b0;
      index_q  <= '0;
      probes_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      key_q    <= key_d;
      mode_q   <= mode_d;
      found_q  <= found_d;
      index_q  <= index_d;
      probes_q <= probes_d;
    end
  end

  // Next-state and window-narrowing logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    key_d    = key_q;
    mode_d   = mode_q;
    found_d  = found_q;
    index_d  = index_q;
    probes_d = probes_q;
    lo_n     = lo_q;
    hi_n     = hi_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          lo_d     = '0;
          hi_d     = N_ENTRIES;
          key_d    = key;
          mode_d   = mode;
          found_d  = 1'b0;
          index_d  = '0;
          probes_d = '0;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        probes_d = probes_q + PW'(1);
        state_d  = S_CMP;
      end
      S_CMP: begin
        if (is_exact && data_eq) begin
          index_d = mid;
          found_d = 1'b1;
          state_d = S_DONE;
        end else begin
          // Upper-bound treats equal as "too small" to land one past the last duplicate.
          if (data_lt || (is_upper && data_eq)) lo_n = mid + IW'(1);
          else                                  hi_n = mid;
          lo_d = lo_n;
          hi_d = hi_n;
          if (lo_n == hi_n) begin
            index_d = lo_n;
            found_d = is_exact ? 1'b0 : (lo_n < N_ENTRIES);
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      found_d  = 1'b0;
      index_d  = '0;
      probes_d = '0;
    end
  end

  // Moore outputs decoded from the current state; results come straight from flops.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    rd_en   = (state_q == S_READ);
    rd_addr = (state_q == S_READ) ? mid[AW-1:0] : '0;
    found   = found_q;
    index   = index_q;
    probes  = probes_q;
  end

endmodule

// File: tb/tb_binary_search_engine.sv
// Directed bench: unsigned and signed engines, each backed by a 1-cycle-latency RAM model.
module tb_binary_search_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, s_start, s_abort;
  logic [1:0] mode, s_mode;
  logic [7:0] key, s_key, rd_data, s_rd_data;
  logic       rd_en, s_rd_en, busy, s_busy, done, s_done, found, s_found;
  logic [3:0] rd_addr, s_rd_addr, index, s_index;
  logic [2:0] probes, s_probes;

  logic [7:0] mem  [0:9];
  logic [7:0] smem [0:9];

  int checks = 0;
  int failures = 0;
  int addrs[$];
  int cyc, saw_done;
  bit gd, f;
  logic [3:0] idx;
  logic [2:0] pr;

  always #5 clk = ~clk;

  binary_search_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(10), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .found(found), .index(index), .probes(probes));

  binary_search_engine #(.DATA_WIDTH(8), .ARRAY_SIZE(10), .SIGNED(1)) sdut (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .key(s_key), .abort(s_abort),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .busy(s_busy), .done(s_done),
    .found(s_found), .index(s_index), .probes(s_probes));

  // Synchronous table RAMs: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= mem[rd_addr];
    if (s_rd_en) s_rd_data <= smem[s_rd_addr];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Runs one search; optionally re-pulses start (with a different key) at cycle restart_at.
  task automatic do_search(input bit s, input logic [1:0] m, input logic [7:0] k,
                           input int restart_at, output int c_out, output bit got,
                           output bit f_o, output logic [3:0] i_o, output logic [2:0] p_o);
    got = 0; c_out = 0; f_o = 0; i_o = '0; p_o = '0;
    addrs.delete();
    @(negedge clk);
    if (s) begin s_start = 1; s_mode = m; s_key = k; end
    else   begin start = 1;   mode = m;   key = k;   end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (s) begin
        s_start = (c == restart_at);
        if (c == restart_at) s_key = 8'd41;
      end else begin
        start = (c == restart_at);
        if (c == restart_at) key = 8'd41;
      end
      if (!s && rd_en) addrs.push_back(int'(rd_addr));
      if (s ? s_done : done) begin
        got = 1; c_out = c;
        f_o = s ? s_found : found;
        i_o = s ? s_index : index;
        p_o = s ? s_probes : probes;
        break;
      end
    end
    start = 0; s_start = 0;
  endtask

  initial begin
    mem[0] = 3;  mem[1] = 7;  mem[2] = 7;  mem[3] = 9;  mem[4] = 12;
    mem[5] = 15; mem[6] = 20; mem[7] = 22; mem[8] = 30; mem[9] = 41;
    smem[0] = 8'hF0; smem[1] = 8'hF8; smem[2] = 8'hFE; smem[3] = 8'h00; smem[4] = 8'h03;
    smem[5] = 8'h05; smem[6] = 8'h10; smem[7] = 8'h20; smem[8] = 8'h40; smem[9] = 8'h7F;
    start = 0; abort = 0; mode = 0; key = 0;
    s_start = 0; s_abort = 0; s_mode = 0; s_key = 0;
    rst = 1;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_index", index, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_probes", probes, 0);
    @(negedge clk); rst = 0;

    // exact 12: mids 5,2,4; done in cycle 7
    do_search(0, 2'b00, 8'd12, 0, cyc, gd, f, idx, pr);
    chk("ex12_done", gd, 1);
    chk("ex12_cycle", cyc, 7);
    chk("ex12_found", f, 1);
    chk("ex12_index", idx, 4);
    chk("ex12_probes", pr, 3);
    chk("ex12_nreads", addrs.size(), 3);
    if (addrs.size() == 3) begin
      chk("ex12_addr0", addrs[0], 5);
      chk("ex12_addr1", addrs[1], 2);
      chk("ex12_addr2", addrs[2], 4);
    end
    @(negedge clk);
    chk("hold_done_low", done, 0);
    chk("hold_index", index, 4);
    chk("hold_found", found, 1);

    do_search(0, 2'b00, 8'd8, 0, cyc, gd, f, idx, pr);
    chk("ex8_done", gd, 1);
    chk("ex8_found", f, 0);
    chk("ex8_index", idx, 3);
    chk("ex8_probes", pr, 4);

    do_search(0, 2'b01, 8'd7, 0, cyc, gd, f, idx, pr);
    chk("lb7_index", idx, 1);
    chk("lb7_found", f, 1);
    chk("lb7_probes", pr, 4);

    do_search(0, 2'b10, 8'd7, 0, cyc, gd, f, idx, pr);
    chk("ub7_index", idx, 3);
    chk("ub7_found", f, 1);
    chk("ub7_cycle", cyc, 9);

    do_search(0, 2'b10, 8'd41, 0, cyc, gd, f, idx, pr);
    chk("ub41_index", idx, 10);
    chk("ub41_found", f, 0);
    chk("ub41_probes", pr, 3);

    do_search(0, 2'b01, 8'd2, 0, cyc, gd, f, idx, pr);
    chk("lb2_index", idx, 0);
    chk("lb2_found", f, 1);

    do_search(0, 2'b11, 8'd30, 0, cyc, gd, f, idx, pr);
    chk("m3_30_index", idx, 8);
    chk("m3_30_found", f, 1);
    chk("m3_30_probes", pr, 2);

    // Second start mid-search must be ignored
    do_search(0, 2'b00, 8'd12, 2, cyc, gd, f, idx, pr);
    chk("restart_index", idx, 4);
    chk("restart_cycle", cyc, 7);

    // Abort in COMPARE
    @(negedge clk); start = 1; mode = 2'b01; key = 8'd7;
    @(negedge clk); start = 0;
    @(negedge clk); abort = 1;
    @(negedge clk); abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_rd_en", rd_en, 0);
    chk("abort_probes", probes, 0);
    saw_done = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    chk("abort_no_done", saw_done, 0);

    // Abort beats start in IDLE
    @(negedge clk); start = 1; abort = 1;
    @(negedge clk); start = 0; abort = 0;
    chk("abort_prio_busy", busy, 0);

    // Asynchronous reset between edges mid-search
    @(negedge clk); start = 1; mode = 2'b00; key = 8'd12;
    @(negedge clk); start = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_en", rd_en, 0);
    chk("arst_probes", probes, 0);
    chk("arst_found", found, 0);
    @(negedge clk); rst = 0;

    do_search(0, 2'b00, 8'd41, 0, cyc, gd, f, idx, pr);
    chk("post_rst_index", idx, 9);
    chk("post_rst_found", f, 1);
    chk("post_rst_probes", pr, 3);

    // Signed ordering: 0xF0.. negatives sort before positives
    do_search(1, 2'b00, 8'hFE, 0, cyc, gd, f, idx, pr);
    chk("sgn_exFE_done", gd, 1);
    chk("sgn_exFE_index", idx, 2);
    chk("sgn_exFE_found", f, 1);
    chk("sgn_exFE_probes", pr, 2);
    do_search(1, 2'b01, 8'h00, 0, cyc, gd, f, idx, pr);
    chk("sgn_lb0_index", idx, 3);
    chk("sgn_lb0_found", f, 1);
    chk("sgn_lb0_probes", pr, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
